// File: rtl/lc3b_types.sv
// Shared LC-3b types plus the L2 controller state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cache_line;

  localparam int LINE_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } l2_state_e;

endpackage

// File: rtl/l2_cache_param_if.sv
// L1-arbiter and physical-memory bus bundle for the parametrised L2 cache.
interface l2_cache_param_if;
  import lc3b_types::*;

  lc3b_word       l2arb_mem_address;
  logic           l2arb_mem_read;
  logic           l2arb_mem_write;
  lc3b_cache_line l2arb_mem_wdata;
  lc3b_cache_line l2arb_mem_rdata;
  logic           l2arb_mem_resp;

  lc3b_word       pmem_address;
  logic           pmem_read;
  logic           pmem_write;
  lc3b_cache_line pmem_wdata;
  lc3b_cache_line pmem_rdata;
  logic           pmem_resp;

  modport slave (
    input  l2arb_mem_address, l2arb_mem_read, l2arb_mem_write, l2arb_mem_wdata,
    output l2arb_mem_rdata, l2arb_mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output l2arb_mem_address, l2arb_mem_read, l2arb_mem_write, l2arb_mem_wdata,
    input  l2arb_mem_rdata, l2arb_mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/l2_cache_param_plru.sv
// Per-set tree pseudo-LRU: heap-ordered nodes (children of n are 2n+1, 2n+2),
// a node bit of 0 steers the victim walk toward the lower ways.
module l2_plru_tree #(
  parameter int WAYS = 4,
  parameter int SETS = 8,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] index,
  output logic [WAY_W-1:0] victim,
  input  logic [WAY_W-1:0] way,
  input  logic             touch
);

  logic [WAYS-2:0] bits [SETS];
  logic [WAYS-2:0] cur;
  logic [WAYS-2:0] upd;

  always_comb begin
    int node;
    logic sel;
    cur  = bits[index];
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      sel = 1'b0;
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == node) sel = cur[n];
      end
      node = 2 * node + 1 + (sel ? 1 : 0);
    end
    victim = WAY_W'(node - (WAYS - 1));
  end

  // Climb from the touched leaf, pointing each ancestor at the opposite subtree.
  always_comb begin
    int child;
    int parent;
    upd   = cur;
    child = int'(way) + WAYS - 1;
    for (int l = 0; l < WAY_W; l++) begin
      parent = (child - 1) / 2;
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == parent) upd[n] = (child % 2 == 1);
      end
      child = parent;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) bits[s] <= '0;
    end else if (touch) begin
      bits[index] <= upd;
    end
  end

endmodule

// File: rtl/l2_cache_param.sv
// N-way set-associative write-back, write-allocate L2 with tree PLRU
// replacement and saturating hit/miss counters.
module l2_cache_param
  import lc3b_types::*;
#(
  parameter int WAYS    = 4,
  parameter int SETS    = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  l2_cache_param_if.slave    bus,
  output logic [COUNT_W-1:0] hit_count,
  output logic [COUNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = 16 - LINE_OFFSET_BITS - IDX_W;

  logic [WAYS-1:0] valid_arr [SETS];
  logic [WAYS-1:0] dirty_arr [SETS];
  logic [TAG_W-1:0] tag_arr [SETS][WAYS];
  lc3b_cache_line   data_arr [SETS][WAYS];

  l2_state_e state_q, state_d;
  logic [WAY_W-1:0] victim_q, miss_victim, plru_victim, hit_way, inv_way;
  logic hit, inv_found, req;
  logic touch, hit_fire, miss_fire, store, fill;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign idx = bus.l2arb_mem_address[LINE_OFFSET_BITS +: IDX_W];
  assign tag = bus.l2arb_mem_address[15 -: TAG_W];
  assign req = bus.l2arb_mem_read | bus.l2arb_mem_write;

  l2_plru_tree #(.WAYS(WAYS), .SETS(SETS)) plru (
    .clk    (clk),
    .rst_n  (rst_n),
    .index  (idx),
    .victim (plru_victim),
    .way    (hit_way),
    .touch  (touch)
  );

  // Invalid ways are scanned downward so the lowest-numbered one wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_arr[idx][w] && tag_arr[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_arr[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    miss_victim = inv_found ? inv_way : plru_victim;
  end

  assign bus.l2arb_mem_rdata = data_arr[idx][hit_way];

  always_comb begin
    state_d          = state_q;
    bus.l2arb_mem_resp = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    touch            = 1'b0;
    hit_fire         = 1'b0;
    miss_fire        = 1'b0;
    store            = 1'b0;
    fill             = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          bus.l2arb_mem_resp = 1'b1;
          touch    = 1'b1;
          hit_fire = 1'b1;
          store    = bus.l2arb_mem_write;
        end else if (req) begin
          miss_fire = 1'b1;
          state_d   = (valid_arr[idx][miss_victim] && dirty_arr[idx][miss_victim])
                      ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {tag_arr[idx][victim_q], idx, {LINE_OFFSET_BITS{1'b0}}};
        bus.pmem_wdata   = data_arr[idx][victim_q];
        if (bus.pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {tag, idx, {LINE_OFFSET_BITS{1'b0}}};
        if (bus.pmem_resp) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      victim_q   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (miss_fire) victim_q <= miss_victim;
      if (store) dirty_arr[idx][hit_way] <= 1'b1;
      if (fill) begin
        valid_arr[idx][victim_q] <= 1'b1;
        dirty_arr[idx][victim_q] <= 1'b0;
      end
      if (hit_fire && hit_count != '1) hit_count <= hit_count + COUNT_W'(1);
      if (miss_fire && miss_count != '1) miss_count <= miss_count + COUNT_W'(1);
    end
  end

  // Tag and data storage carries no reset; writes are still blocked while in reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (store) data_arr[idx][hit_way] <= bus.l2arb_mem_wdata;
      if (fill) begin
        data_arr[idx][victim_q] <= bus.pmem_rdata;
        tag_arr[idx][victim_q]  <= tag;
      end
    end
  end

endmodule

// File: doc/l2_cache_param.md
Name: l2_cache_param

Overview:
Parametrised N-way set-associative, write-back, write-allocate L2 cache. It is the next generation of the fixed 4-way L2 and sits between the L1 arbiter (l2arb_*) and physical memory (pmem_*).
- Adds configurable ways and sets.
- Adds tree pseudo-LRU replacement, with invalid ways preferred as victims.
- Adds saturating hit and miss counters.

Parameters:
- WAYS, 4, associativity; power of two, at least 2.
- SETS, 8, number of sets; power of two.
- COUNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- l2arb_mem_address  in  16  byte address (lc3b_word).
- l2arb_mem_read  in  1  read request, held until resp.
- l2arb_mem_write  in  1  write request, held until resp.
- l2arb_mem_wdata  in  128  full line to write (lc3b_cache_line).
- l2arb_mem_rdata  out  128  line read.
- l2arb_mem_resp  out  1  single-cycle completion pulse.
- pmem_address  out  16  line-aligned memory address.
- pmem_read  out  1  memory line read.
- pmem_write  out  1  memory line write.
- pmem_wdata  out  128  victim line.
- pmem_rdata  in  128  fill line.
- pmem_resp  in  1  memory completion.
- hit_count  out  COUNT_W  saturating hit counter.
- miss_count  out  COUNT_W  saturating miss counter.

Behaviour:
- Address split: offset = addr[3:0], ignored. Index = addr[4 +: log2(SETS)]. Tag = remaining upper bits.
- Storage is flop arrays. Valid, dirty and PLRU state are reset; tag and data arrays are not reset.
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; all valid, dirty and PLRU bits clear; both counters clear.
  - l2arb_mem_resp, pmem_read and pmem_write are 0 from the following cycle.
  - Reset mid WRITEBACK or ALLOCATE abandons the pmem transaction. No array is updated.
- Read and write asserted together: treated as a write.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE with request, hit (tag compare is combinational):
  - resp=1 in the same cycle.
  - Read: rdata = hit way line.
  - Write: at the edge, load wdata and set dirty.
  - PLRU updated for the hit way at the edge.
  - hit_count increments at the edge.
- IDLE with request, miss:
  - Victim = lowest-numbered invalid way; otherwise the PLRU way.
  - miss_count increments once per miss, at the edge leaving IDLE.
  - Next state: WRITEBACK if the victim is valid and dirty, else ALLOCATE.
- WRITEBACK:
  - pmem_write=1; pmem_address = {victim tag, index, 4'b0}; pmem_wdata = victim line.
  - On pmem_resp, go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1; pmem_address = {request tag, index, 4'b0}.
  - On pmem_resp, load data and tag, set valid=1, dirty=0, go to IDLE. PLRU is not touched.
  - The request, still held, then hits in IDLE. That hit counts in hit_count.
- The victim way is latched on leaving IDLE and held through WRITEBACK and ALLOCATE.
- pmem outputs are 0 in IDLE. resp is 0 outside IDLE.
- PLRU is a tree of WAYS-1 bits per set:
  - Victim walk from the root: bit 0 = go left (lower ways), bit 1 = go right.
  - On touch of way w: every node on w's path is set to point away from w.
- Counters saturate at all-ones and do not wrap.
- Requester protocol: address and data are stable while the request is held. The request is deasserted or changed only after resp.

Decomposition:
- Shared package (lc3b_types):
  - lc3b_word and lc3b_cache_line, reused as-is.
  - Add a constant LINE_OFFSET_BITS = 4.
- Sub-module l2_plru_tree, parametrised by WAYS and SETS:
  - Holds the per-set PLRU bits.
  - Combinational victim output for the presented index.
  - Synchronous update port: index, way, enable.
- Control FSM and datapath are kept in one file.

Test Plan:
All scenarios use WAYS=4, SETS=8; set 4 tags via 0x0040, 0x00C0, 0x0140, 0x01C0, 0x0240.
1. Cold miss then hit:
   - After reset, read 0x0040 -> pmem_read with pmem_address=0x0040; pmem returns line A -> resp with rdata=A; miss_count=1.
   - Re-read 0x0040 -> resp in the same cycle, no pmem activity, hit_count=2.
2. Write hit, then PLRU fill:
   - Write line B to 0x0040 -> dirty set.
   - Fill 0x00C0, 0x0140, 0x01C0 (ways 1-3, invalid-first).
   - Read 0x0240 -> PLRU victim way0. pmem_write to 0x0040 with B precedes pmem_read to 0x0240.
3. PLRU re-touch:
   - After a clean fill of set 4, re-read 0x0040.
   - Then read 0x0240 -> victim way2 (0x0140); no pmem_write because it is clean; 0x0140 now misses.
4. Simultaneous read and write on 0x0040 with wdata C -> treated as a write; a later read returns C.
5. Reset mid-WRITEBACK:
   - Drop rst_n while pmem_write=1 -> pmem_write=0 next cycle; counters=0.
   - Read 0x0040 -> misses.
6. Counter saturation: COUNT_W=2, five hits -> hit_count holds 3.
